// File: rtl/cpu0_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : cpu0_mem_arbiter
// Purpose  : Shares the single cpu0 memory bus between an instruction-fetch
//            port and a load/store data port. Each access runs a fixed
//            MEM_LAT-cycle bus cycle. Read data is captured into a per-port
//            register, and sub-word data loads are optionally sign-extended.
//            Misaligned accesses are answered with err and never reach the bus.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
// Parameters:
//   MEM_LAT   - bus cycles m_en is held per access (1..15)
//   ALIGN_CHK - 1: reject misaligned INT32/INT16, 0: pass everything to bus
// Optional build macro:
//   CPU0_ARB_RR_EN - round-robin arbitration (default: data over inst)
// Ports:
//   clock, reset             - rising-edge clock, async active-low reset
//   i_req/i_addr             - fetch request (always a 32-bit read)
//   i_ack/i_err/i_rdata      - fetch completion pulse, error, fetched word
//   d_req/d_rw/d_size/d_sext - data request, 1=read, size code, sign-extend
//   d_addr/d_wdata           - data address and write data
//   d_ack/d_err/d_rdata      - data completion pulse, error, load result
//   m_en/m_rw/m_size/mar/mdr - memory bus outputs
//   dbus_in                  - memory read data
//   grant                    - one-hot owner (bit0 inst, bit1 data)
// ============================================================================
module cpu0_mem_arbiter #(
  parameter int MEM_LAT   = 1,
  parameter bit ALIGN_CHK = 1'b1
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        i_req,
  input  logic [31:0] i_addr,
  output logic        i_ack,
  output logic        i_err,
  output logic [31:0] i_rdata,
  input  logic        d_req,
  input  logic        d_rw,
  input  logic [1:0]  d_size,
  input  logic        d_sext,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  output logic        d_ack,
  output logic        d_err,
  output logic [31:0] d_rdata,
  output logic        m_en,
  output logic        m_rw,
  output logic [1:0]  m_size,
  output logic [31:0] mar,
  output logic [31:0] mdr,
  input  logic [31:0] dbus_in,
  output logic [1:0]  grant
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_DONE   = 2'd2,
    ST_ERR    = 2'd3
  } state_e;

  localparam logic [3:0] LAT_LOAD = 4'(MEM_LAT - 1);
  localparam logic [1:0] SZ_INT32 = 2'b11;
  localparam logic [1:0] SZ_INT16 = 2'b01;
  localparam logic [1:0] SZ_BYTE  = 2'b00;
  localparam logic [1:0] SZ_INT24 = 2'b10;

  state_e      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [1:0]  grant_q, grant_d;
  logic [31:0] mar_q, mar_d;
  logic [31:0] mdr_q, mdr_d;
  logic [1:0]  m_size_q, m_size_d;
  logic        m_rw_q, m_rw_d;
  logic        sext_q, sext_d;
  logic [31:0] i_rdata_q, i_rdata_d;
  logic [31:0] d_rdata_q, d_rdata_d;

  logic elig_i, elig_d, win_any, win_data, win_misalign, prefer_data;

  function automatic logic misaligned(input logic [1:0] size, input logic [31:0] addr);
    logic bad;
    bad = 1'b0;
    if (ALIGN_CHK) begin
      if (size == SZ_INT32) bad = (addr[1:0] != 2'b00);
      else if (size == SZ_INT16) bad = addr[0];
    end
    return bad;
  endfunction

  function automatic logic [31:0] extend(input logic [31:0] raw, input logic [1:0] size,
                                         input logic sext);
    logic [31:0] r;
    r = raw;
    if (sext) begin
      case (size)
        SZ_BYTE:  r = {{24{raw[7]}}, raw[7:0]};
        SZ_INT16: r = {{16{raw[15]}}, raw[15:0]};
        SZ_INT24: r = {{8{raw[23]}}, raw[23:0]};
        default:  r = raw;
      endcase
    end
    return r;
  endfunction

`ifdef CPU0_ARB_RR_EN
  // Last owner: 0 = inst, 1 = data. Data is preferred when inst went last.
  logic last_q, last_d;

  assign prefer_data = ~last_q;

  always_comb begin
    last_d = last_q;
    if (state_q == ST_DONE || state_q == ST_ERR) last_d = grant_q[1];
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) last_q <= 1'b0;
    else        last_q <= last_d;
  end
`else
  assign prefer_data = 1'b1;
`endif

  // In DONE/ERR grant_q still names the finishing owner, whose req is still
  // high during its ack cycle; only the other port may be picked then.
  always_comb begin
    elig_i       = i_req && ((state_q == ST_IDLE) || grant_q[1]);
    elig_d       = d_req && ((state_q == ST_IDLE) || grant_q[0]);
    win_any      = elig_i || elig_d;
    win_data     = elig_d && (!elig_i || prefer_data);
    win_misalign = win_data ? misaligned(d_size, d_addr) : misaligned(SZ_INT32, i_addr);
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    grant_d   = grant_q;
    mar_d     = mar_q;
    mdr_d     = mdr_q;
    m_size_d  = m_size_q;
    m_rw_d    = m_rw_q;
    sext_d    = sext_q;
    i_rdata_d = i_rdata_q;
    d_rdata_d = d_rdata_q;

    case (state_q)
      ST_ACCESS: begin
        if (cnt_q == 4'd0) begin
          state_d = ST_DONE;
          if (grant_q[0])  i_rdata_d = dbus_in;
          else if (m_rw_q) d_rdata_d = extend(dbus_in, m_size_q, sext_q);
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      // IDLE, DONE and ERR all share the same launch decision.
      default: begin
        if (win_any) begin
          grant_d = win_data ? 2'b10 : 2'b01;
          if (win_misalign) begin
            state_d = ST_ERR;
          end else begin
            state_d = ST_ACCESS;
            cnt_d   = LAT_LOAD;
            if (win_data) begin
              mar_d    = d_addr;
              mdr_d    = d_wdata;
              m_size_d = d_size;
              m_rw_d   = d_rw;
              sext_d   = d_sext;
            end else begin
              mar_d    = i_addr;
              m_size_d = SZ_INT32;
              m_rw_d   = 1'b1;
            end
          end
        end else begin
          state_d = ST_IDLE;
          grant_d = 2'b00;
        end
      end
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q   <= ST_IDLE;
      cnt_q     <= 4'd0;
      grant_q   <= 2'b00;
      mar_q     <= 32'd0;
      mdr_q     <= 32'd0;
      m_size_q  <= 2'b00;
      m_rw_q    <= 1'b0;
      sext_q    <= 1'b0;
      i_rdata_q <= 32'd0;
      d_rdata_q <= 32'd0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      grant_q   <= grant_d;
      mar_q     <= mar_d;
      mdr_q     <= mdr_d;
      m_size_q  <= m_size_d;
      m_rw_q    <= m_rw_d;
      sext_q    <= sext_d;
      i_rdata_q <= i_rdata_d;
      d_rdata_q <= d_rdata_d;
    end
  end

  assign m_en    = (state_q == ST_ACCESS);
  assign i_ack   = ((state_q == ST_DONE) || (state_q == ST_ERR)) && grant_q[0];
  assign d_ack   = ((state_q == ST_DONE) || (state_q == ST_ERR)) && grant_q[1];
  assign i_err   = (state_q == ST_ERR) && grant_q[0];
  assign d_err   = (state_q == ST_ERR) && grant_q[1];
  assign i_rdata = i_rdata_q;
  assign d_rdata = d_rdata_q;
  assign m_rw    = m_rw_q;
  assign m_size  = m_size_q;
  assign mar     = mar_q;
  assign mdr     = mdr_q;
  assign grant   = grant_q;

endmodule
`default_nettype wire

// File: tb/tb_cpu0_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_cpu0_mem_arbiter
// Purpose  : Self-checking bench for cpu0_mem_arbiter. A byte-array memory
//            answers the bus; expected results come from access rules
//            (latency, alignment, big-endian byte order, sign extension).
// Revision : 1.0 - initial release
// ============================================================================
module tb_cpu0_mem_arbiter;

  localparam int MEM_LAT = 3;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        i_req = 1'b0;
  logic [31:0] i_addr = 32'd0;
  logic        i_ack, i_err;
  logic [31:0] i_rdata;
  logic        d_req = 1'b0;
  logic        d_rw = 1'b0;
  logic [1:0]  d_size = 2'b00;
  logic        d_sext = 1'b0;
  logic [31:0] d_addr = 32'd0;
  logic [31:0] d_wdata = 32'd0;
  logic        d_ack, d_err;
  logic [31:0] d_rdata;
  logic        m_en, m_rw;
  logic [1:0]  m_size;
  logic [31:0] mar, mdr;
  logic [31:0] dbus_in;
  logic [1:0]  grant;

  int total = 0;
  int bad   = 0;
  logic [31:0] exp_i_rdata = 32'd0;
  logic [31:0] exp_d_rdata = 32'd0;

  // memory model
  logic [7:0]  mem [0:4095];
  logic        fill_req = 1'b0;
  logic        pl_we = 1'b0;
  logic [11:0] pl_addr = 12'd0;
  logic [7:0]  pl_byte = 8'd0;

  cpu0_mem_arbiter #(.MEM_LAT(MEM_LAT), .ALIGN_CHK(1'b1)) dut (
    .clock(clock), .reset(reset),
    .i_req(i_req), .i_addr(i_addr), .i_ack(i_ack), .i_err(i_err), .i_rdata(i_rdata),
    .d_req(d_req), .d_rw(d_rw), .d_size(d_size), .d_sext(d_sext), .d_addr(d_addr),
    .d_wdata(d_wdata), .d_ack(d_ack), .d_err(d_err), .d_rdata(d_rdata),
    .m_en(m_en), .m_rw(m_rw), .m_size(m_size), .mar(mar), .mdr(mdr),
    .dbus_in(dbus_in), .grant(grant)
  );

  always #5 clock = ~clock;

  // Big-endian: the lowest address holds the most significant byte.
  always_comb begin
    dbus_in = 32'd0;
    for (int k = 0; k < 4; k++)
      if (k <= int'(m_size)) dbus_in = (dbus_in << 8) | {24'd0, mem[mar[11:0] + 12'(k)]};
  end

  always @(posedge clock) begin
    if (fill_req) begin
      for (int k = 0; k < 4096; k++) mem[k] <= 8'((k * 91) ^ (k >> 3));
    end else if (pl_we) begin
      mem[pl_addr] <= pl_byte;
    end else if (m_en && !m_rw) begin
      for (int k = 0; k < 4; k++)
        if (k <= int'(m_size)) mem[mar[11:0] + 12'(k)] <= 8'(mdr >> (8 * (int'(m_size) - k)));
    end
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic preload(input logic [11:0] a, input logic [7:0] b);
    pl_we = 1'b1; pl_addr = a; pl_byte = b;
    tick();
    pl_we = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    i_req = 1'b0; d_req = 1'b0;
    repeat (2) tick();
    reset = 1'b1;
    exp_i_rdata = 32'd0;
    exp_d_rdata = 32'd0;
  endtask

  // One complete transaction on one port, checked against the access rules.
  task automatic do_xfer(input bit is_d, input bit rw_in, input logic [1:0] size_in,
                         input bit sext, input logic [31:0] addr, input logic [31:0] wdata,
                         input string tag);
    int n, lat, cyc, men;
    bit mis, got, rw;
    logic [1:0]  size;
    logic [31:0] v, exp_rd, act_rd;
    logic [7:0]  eb;
    rw   = is_d ? rw_in : 1'b1;
    size = is_d ? size_in : 2'b11;
    n    = int'(size) + 1;
    mis  = (size == 2'b11 && addr[1:0] != 2'b00) || (size == 2'b01 && addr[0]);
    lat  = mis ? 1 : 1 + MEM_LAT;
    v = 32'd0;
    for (int k = 0; k < n; k++) v = (v << 8) | {24'd0, mem[addr[11:0] + 12'(k)]};
    if (is_d && sext && n < 4 && v[8 * n - 1]) v = v - (32'd1 << (8 * n));
    if (!mis && rw) begin
      if (is_d) exp_d_rdata = v; else exp_i_rdata = v;
    end
    exp_rd = is_d ? exp_d_rdata : exp_i_rdata;

    if (is_d) begin
      d_rw = rw; d_size = size; d_sext = sext; d_addr = addr; d_wdata = wdata; d_req = 1'b1;
    end else begin
      i_addr = addr; i_req = 1'b1;
    end
    cyc = 0; men = 0; got = 1'b0;
    while (!got && cyc < 50) begin
      tick();
      cyc++;
      if (m_en) begin
        if (men == 0) begin
          total++;
          if (mar !== addr || m_rw !== rw || m_size !== size ||
              grant !== (is_d ? 2'b10 : 2'b01) || (is_d && !rw && mdr !== wdata)) begin
            bad++;
            $display("FAIL %s bus: mar=%h rw=%b size=%b grant=%b mdr=%h, need mar=%h rw=%b size=%b mdr=%h",
                     tag, mar, m_rw, m_size, grant, mdr, addr, rw, size, wdata);
          end
        end
        men++;
      end
      if (is_d ? i_ack : d_ack) begin
        total++; bad++;
        $display("FAIL %s wrong-port ack at cycle %0d", tag, cyc);
      end
      got = is_d ? d_ack : i_ack;
    end
    act_rd = is_d ? d_rdata : i_rdata;
    total++;
    if (!got) begin
      bad++; $display("FAIL %s timeout: no ack within %0d cycles", tag, cyc);
    end else if (cyc !== lat) begin
      bad++; $display("FAIL %s latency: got %0d cycles, need %0d", tag, cyc, lat);
    end
    total++;
    if ((is_d ? d_err : i_err) !== mis) begin
      bad++; $display("FAIL %s err: got %b need %b", tag, (is_d ? d_err : i_err), mis);
    end
    total++;
    if (act_rd !== exp_rd) begin
      bad++; $display("FAIL %s rdata: got %h need %h", tag, act_rd, exp_rd);
    end
    total++;
    if (men !== (mis ? 0 : MEM_LAT)) begin
      bad++; $display("FAIL %s m_en cycles: got %0d need %0d", tag, men, (mis ? 0 : MEM_LAT));
    end
    if (is_d) d_req = 1'b0; else i_req = 1'b0;
    tick();
    total++;
    if (i_ack !== 1'b0 || d_ack !== 1'b0 || grant !== 2'b00 || m_en !== 1'b0) begin
      bad++; $display("FAIL %s after-ack: i_ack=%b d_ack=%b grant=%b m_en=%b, need all 0",
                      tag, i_ack, d_ack, grant, m_en);
    end
    if (is_d && !rw && !mis) begin
      for (int k = 0; k < n; k++) begin
        eb = 8'(wdata >> (8 * (n - 1 - k)));
        total++;
        if (mem[addr[11:0] + 12'(k)] !== eb) begin
          bad++; $display("FAIL %s mem[%h]: got %h need %h", tag, addr[11:0] + 12'(k),
                          mem[addr[11:0] + 12'(k)], eb);
        end
      end
    end
  endtask

  task automatic test_reset();
    do_reset();
    total++;
    if ({m_en, m_rw, m_size, mar, mdr, grant} !== 70'd0) begin
      bad++; $display("FAIL reset bus: m_en=%b m_rw=%b m_size=%b mar=%h mdr=%h grant=%b, need 0",
                      m_en, m_rw, m_size, mar, mdr, grant);
    end
    total++;
    if ({i_ack, i_err, d_ack, d_err} !== 4'd0) begin
      bad++; $display("FAIL reset ack: %b need 0000", {i_ack, i_err, d_ack, d_err});
    end
    total++;
    if (i_rdata !== 32'd0 || d_rdata !== 32'd0) begin
      bad++; $display("FAIL reset rdata: i=%h d=%h need 0", i_rdata, d_rdata);
    end
  endtask

  task automatic test_fetch();
    preload(12'h010, 8'h09); preload(12'h011, 8'h12);
    preload(12'h012, 8'h00); preload(12'h013, 8'h04);
    do_xfer(1'b0, 1'b1, 2'b11, 1'b0, 32'h10, 32'd0, "fetch");
    total++;
    if (i_rdata !== 32'h0912_0004) begin
      bad++; $display("FAIL fetch word: got %h need 09120004", i_rdata);
    end
  endtask

  task automatic test_byte_load();
    preload(12'h103, 8'h85);
    do_xfer(1'b1, 1'b1, 2'b00, 1'b1, 32'h103, 32'd0, "lb_sext");
    total++;
    if (d_rdata !== 32'hFFFF_FF85) begin
      bad++; $display("FAIL lb_sext value: got %h need ffffff85", d_rdata);
    end
    do_xfer(1'b1, 1'b1, 2'b00, 1'b0, 32'h103, 32'd0, "lb_zext");
    total++;
    if (d_rdata !== 32'h0000_0085) begin
      bad++; $display("FAIL lb_zext value: got %h need 00000085", d_rdata);
    end
    // halfword and 24-bit signed loads
    preload(12'h120, 8'h9A); preload(12'h121, 8'h01); preload(12'h122, 8'h02);
    do_xfer(1'b1, 1'b1, 2'b01, 1'b1, 32'h120, 32'd0, "lh_sext");
    do_xfer(1'b1, 1'b1, 2'b10, 1'b1, 32'h120, 32'd0, "l24_sext");
  endtask

  task automatic test_half_write();
    do_xfer(1'b1, 1'b0, 2'b01, 1'b0, 32'h200, 32'h1234_ABCD, "sh");
    total++;
    if (mem[12'h200] !== 8'hAB || mem[12'h201] !== 8'hCD) begin
      bad++; $display("FAIL sh bytes: got %h%h need abcd", mem[12'h200], mem[12'h201]);
    end
  endtask

  task automatic test_misaligned();
    do_xfer(1'b1, 1'b1, 2'b11, 1'b0, 32'h102, 32'd0, "mis_word");
    do_xfer(1'b1, 1'b0, 2'b01, 1'b0, 32'h201, 32'h5555_5555, "mis_half_wr");
    do_xfer(1'b0, 1'b1, 2'b11, 1'b0, 32'h102, 32'd0, "mis_fetch");
  endtask

  task automatic test_contention();
    bit expq[$];
    bit gotq[$];
    int pend [2];
    bit w, last_owner;
    int cyc;
    do_reset();
    // model: port 1 = data, 0 = inst
    pend[0] = 3; pend[1] = 3; last_owner = 1'b0;
`ifdef CPU0_ARB_RR_EN
    w = !last_owner;
`else
    w = 1'b1;
`endif
    while (pend[0] + pend[1] > 0) begin
      expq.push_back(w);
      pend[w]--;
      last_owner = w;
      if (pend[!w] > 0) w = !w;
    end
    pend[0] = 3; pend[1] = 3;
    i_addr = 32'h40; d_addr = 32'h80; d_rw = 1'b1; d_size = 2'b11; d_sext = 1'b0;
    i_req = 1'b1; d_req = 1'b1;
    cyc = 0;
    while ((i_req || d_req) && cyc < 200) begin
      tick();
      cyc++;
      if (d_ack) begin
        gotq.push_back(1'b1); pend[1]--; if (pend[1] == 0) d_req = 1'b0;
      end
      if (i_ack) begin
        gotq.push_back(1'b0); pend[0]--; if (pend[0] == 0) i_req = 1'b0;
      end
    end
    i_req = 1'b0; d_req = 1'b0;
    tick(); tick();
    total++;
    if (gotq.size() != expq.size()) begin
      bad++; $display("FAIL contention count: got %0d acks need %0d", gotq.size(), expq.size());
    end
    for (int k = 0; k < expq.size() && k < gotq.size(); k++) begin
      total++;
      if (gotq[k] !== expq[k]) begin
        bad++; $display("FAIL contention order[%0d]: got %s need %s", k,
                        gotq[k] ? "data" : "inst", expq[k] ? "data" : "inst");
      end
    end
    total++;
    if (i_rdata !== {mem[12'h40], mem[12'h41], mem[12'h42], mem[12'h43]}) begin
      bad++; $display("FAIL contention i_rdata: got %h", i_rdata);
    end
    exp_i_rdata = i_rdata;
    exp_d_rdata = d_rdata;
  endtask

  task automatic test_reset_mid_access();
    int cyc;
    i_addr = 32'h20; i_req = 1'b1;
    cyc = 0;
    do begin tick(); cyc++; end while (!m_en && cyc < 10);
    tick();
    total++;
    if (m_en !== 1'b1) begin
      bad++; $display("FAIL midrst setup: m_en=%b need 1", m_en);
    end
    #2;
    reset = 1'b0; i_req = 1'b0;
    #1;
    total++;
    if (m_en !== 1'b0 || grant !== 2'b00 || i_ack !== 1'b0 || i_rdata !== 32'd0) begin
      bad++; $display("FAIL midrst immediate: m_en=%b grant=%b i_ack=%b i_rdata=%h need 0",
                      m_en, grant, i_ack, i_rdata);
    end
    exp_i_rdata = 32'd0; exp_d_rdata = 32'd0;
    for (int k = 0; k < 3; k++) begin
      tick();
      total++;
      if (i_ack !== 1'b0 || d_ack !== 1'b0 || m_en !== 1'b0) begin
        bad++; $display("FAIL midrst hold %0d: i_ack=%b d_ack=%b m_en=%b need 0",
                        k, i_ack, d_ack, m_en);
      end
    end
    reset = 1'b1;
    tick();
    do_xfer(1'b0, 1'b1, 2'b11, 1'b0, 32'h24, 32'd0, "midrst_fetch");
  endtask

  task automatic test_random();
    bit is_d, rw, sext;
    logic [1:0]  size;
    logic [31:0] addr, wdata;
    for (int it = 0; it < 40; it++) begin
      is_d  = 1'($urandom_range(0, 1));
      rw    = 1'($urandom_range(0, 1));
      sext  = 1'($urandom_range(0, 1));
      size  = 2'($urandom_range(0, 3));
      addr  = 32'($urandom_range(0, 4092));
      wdata = $urandom;
      do_xfer(is_d, rw, size, sext, addr, wdata, "random");
    end
  endtask

  initial begin
    fill_req = 1'b1;
    tick();
    fill_req = 1'b0;
    test_reset();
    test_fetch();
    test_byte_load();
    test_half_write();
    test_misaligned();
    test_contention();
    test_reset_mid_access();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/cpu0_mem_arbiter.md
Name: cpu0_mem_arbiter

Overview:
- Shares the single cpu0 memory bus (en/rw/size/address/write-data out, read-data in) between an instruction-fetch port and a load/store data port.
- Sequences each access through a fixed-latency bus cycle, captures read data, and sign-extends sub-word loads.
- Rejects misaligned accesses without touching the bus.
- Sits between the cpu0 core and memory0; the core stalls on req until ack.

Parameters:
- MEM_LAT, 1, bus cycles m_en is held per access (legal range 1..15).
- ALIGN_CHK, 1, 1 = reject misaligned INT32/INT16 with err; 0 = pass every access to the bus.

Ports:
- clock  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- i_req  in  1  instruction fetch request; held until i_ack.
- i_addr  in  32  fetch address; access is always a 32-bit read.
- i_ack  out  1  one-cycle completion pulse.
- i_err  out  1  valid with i_ack; misaligned fetch.
- i_rdata  out  32  fetched word; valid with i_ack, held until the next i_ack.
- d_req  in  1  data request; held until d_ack.
- d_rw  in  1  1 = read, 0 = write.
- d_size  in  2  11 = INT32, 10 = INT24, 01 = INT16, 00 = BYTE.
- d_sext  in  1  sign-extend read data (LB/LH); 0 = zero-extend.
- d_addr  in  32  data address.
- d_wdata  in  32  write data.
- d_ack  out  1  one-cycle completion pulse.
- d_err  out  1  valid with d_ack; misaligned access.
- d_rdata  out  32  load result; valid with d_ack.
- m_en  out  1  bus enable.
- m_rw  out  1  bus direction, 1 = read.
- m_size  out  2  bus size code.
- mar  out  32  bus address.
- mdr  out  32  bus write data.
- dbus_in  in  32  memory read data (combinational from memory).
- grant  out  2  one-hot owner: bit0 = inst, bit1 = data; 00 when idle.

Behaviour:
- Reset (reset = 0, asynchronous): state IDLE; every output 0, including m_en, m_rw, m_size, mar, mdr, grant, the ack/err pulses and both rdata registers.
- Reset asserted mid-access aborts immediately: m_en drops and no ack is issued.
- States:
  - IDLE: no requests -> stay. A request pending -> arbitrate. A winner that fails the alignment check -> ERR. Otherwise -> ACCESS, and register mar/mdr/m_size/m_rw from the winning port.
  - ACCESS: m_en = 1 for exactly MEM_LAT cycles, counted by a 4-bit down-counter. On the last cycle, dbus_in is sampled into the winner's rdata (reads only) -> DONE.
  - DONE: m_en = 0 and the winner's ack = 1. If the other port requests, arbitrate it and go directly to ACCESS or ERR; otherwise -> IDLE. The winner's own req is ignored in DONE, because it is still high in its ack cycle.
  - ERR: winner's ack = 1 and err = 1; rdata is unchanged; no bus cycle occurs. Next state follows the same rule as DONE.
- Latency: req sampled high in IDLE -> ack asserted 1 + MEM_LAT cycles later (MEM_LAT = 1 gives ack in the 2nd cycle after the sample edge). Misaligned access: ack one cycle after the sample edge.
- Requesters hold addr/size/wdata/rw/sext stable while req is high. Dropping req before ack is illegal and the result is undefined.
- Alignment (ALIGN_CHK = 1): INT32 requires addr[1:0] = 0; INT16 requires addr[0] = 0; BYTE and INT24 are always aligned. The instruction port is checked as INT32.
- Read extension for the data port:
  - BYTE + d_sext: bits 31:8 = dbus_in[7].
  - INT16 + d_sext: bits 31:16 = dbus_in[15].
  - INT24 + d_sext: bits 31:24 = dbus_in[23].
  - d_sext = 0 or INT32: dbus_in passed through unchanged.
- Writes: mdr = d_wdata unmodified; memory selects the low bytes according to m_size.
- Arbitration: fixed priority, data over instruction. Simultaneous requests in IDLE -> data is granted first and instruction is granted from data's DONE.
- grant is updated on the same edge that enters ACCESS/ERR and cleared on entry to IDLE.
- Bus outputs mar/mdr/m_size/m_rw hold their last values while idle; only m_en qualifies the bus.

Optional Feature:
- Macro: CPU0_ARB_RR_EN.
- Defined: round-robin arbitration. A 1-bit last-owner register, reset to inst, is updated at each ack. On simultaneous requests the port that was not the last owner wins.
- Undefined: fixed data-over-instruction priority as described in Behaviour.

Test Plan:
- Single fetch, MEM_LAT = 1: i_req with i_addr = 0x0000_0010, memory word 0x0912_0004 -> m_en high for 1 cycle with mar = 0x10 and m_rw = 1; i_ack pulses 2 cycles after the sample edge; i_rdata = 0x0912_0004; i_err = 0.
- Signed byte load: d_req, d_rw = 1, d_size = 00, d_sext = 1, d_addr = 0x103, memory byte 0x85 -> d_rdata = 0xFFFF_FF85. Repeat with d_sext = 0 -> 0x0000_0085.
- Halfword write, MEM_LAT = 3: d_rw = 0, d_size = 01, d_addr = 0x200, d_wdata = 0x1234_ABCD -> m_en high for exactly 3 cycles with m_rw = 0, mdr = 0x1234_ABCD, m_size = 01; d_ack follows; memory bytes 0x200/0x201 = AB/CD.
- Misaligned: d_size = 11 with d_addr = 0x102 -> no m_en assertion; d_ack and d_err pulse 1 cycle after the sample edge; d_rdata unchanged.
- Contention: i_req and d_req rise in the same cycle, held for 3 back-to-back transactions each -> fixed priority gives grant sequence data, inst, data, inst… (each port's own req ignored in its ack cycle). With CPU0_ARB_RR_EN the first grant goes to data (last owner after reset is inst), then strict alternation.
- Reset mid-access: reset driven low during ACCESS with MEM_LAT = 4 -> m_en = 0 and grant = 00 immediately; no ack pulse; after release, a new fetch completes normally.
